// File: rtl/sc_io_port_bank_if.sv
// CPU load/store bus as seen by a memory-mapped peripheral.
// The master drives address, store data and strobe; the slave answers with decode and read data.
interface sc_io_port_bank_if #(
  parameter int DW = 32
);
  logic [31:0]   addr;
  logic [DW-1:0] datain;
  logic          we;
  logic          sel;
  logic [DW-1:0] dataout;

  modport master (output addr, datain, we, input sel, dataout);
  modport slave  (input addr, datain, we, output sel, dataout);
endinterface

// File: rtl/sc_io_port_bank.sv
// Memory-mapped I/O bank: R/W output registers, synchronised and debounced inputs,
// a write-1-to-clear change-status register and a maskable registered interrupt.
module sc_io_port_bank #(
  parameter int          DW         = 32,
  parameter int          NUM_OUT    = 3,
  parameter int          NUM_IN     = 2,
  parameter int          DEB_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h80
) (
  input  logic                   clock,
  input  logic                   reset,
  sc_io_port_bank_if.slave       bus,
  output logic [NUM_OUT*DW-1:0]  out_port,
  input  logic [NUM_IN*DW-1:0]   in_port,
  output logic                   irq
);
  localparam logic [15:0] CNT_LAST  = 16'(DEB_CYCLES - 1);
  localparam logic [4:0]  WORD_STAT = 5'h18;
  localparam logic [4:0]  WORD_IEN  = 5'h19;

  logic [31:0]          offset;
  logic [4:0]           word;
  logic                 wr;
  logic                 wr_stat;
  logic                 wr_ien;
  logic [1:0]           unused_offset_lsbs;
  logic [NUM_IN*DW-1:0] stable_flat;
  logic [NUM_IN-1:0]    accept;
  logic [NUM_IN-1:0]    stat_reg;
  logic [NUM_IN-1:0]    stat_next;
  logic [NUM_IN-1:0]    ien_reg;
  logic [NUM_IN-1:0]    ien_next;
  logic [DW-1:0]        rd_data;

  // Subtract first so a window that is not 128-byte aligned still decodes correctly.
  assign offset             = bus.addr - BASE_ADDR;
  assign bus.sel            = (bus.addr >= BASE_ADDR) && (offset[31:7] == 25'd0);
  assign word               = offset[6:2];
  assign unused_offset_lsbs = offset[1:0];
  assign wr                 = bus.we & bus.sel;
  assign wr_stat            = wr && (word == WORD_STAT);
  assign wr_ien             = wr && (word == WORD_IEN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic [DW-1:0] out_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          out_reg <= '0;
        end else if (wr && (word == 5'(gi))) begin
          out_reg <= bus.datain;
        end
      end
      assign out_port[gi*DW +: DW] = out_reg;
    end

    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic [DW-1:0] sync1_reg;
      logic [DW-1:0] sync2_reg;
      logic [DW-1:0] stable_reg;
      logic [15:0]   cnt_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1_reg  <= '0;
          sync2_reg  <= '0;
          stable_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= in_port[gi*DW +: DW];
          sync2_reg <= sync1_reg;
          // Only a return to the accepted value restarts the count.
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      end
      assign accept[gi]                = (sync2_reg != stable_reg) && (cnt_reg == CNT_LAST);
      assign stable_flat[gi*DW +: DW]  = stable_reg;
    end
  endgenerate

  // A change accepted in the same cycle as a clear keeps its bit set.
  always_comb begin
    stat_next = (stat_reg & ~(wr_stat ? bus.datain[NUM_IN-1:0] : '0)) | accept;
    ien_next  = wr_ien ? bus.datain[NUM_IN-1:0] : ien_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_reg <= '0;
      ien_reg  <= '0;
      irq      <= 1'b0;
    end else begin
      stat_reg <= stat_next;
      ien_reg  <= ien_next;
      irq      <= |(stat_next & ien_next);
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.sel) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (word == 5'(i)) rd_data = out_port[i*DW +: DW];
      end
      for (int j = 0; j < NUM_IN; j++) begin
        if (word == 5'(16 + j)) rd_data = stable_flat[j*DW +: DW];
      end
      if (word == WORD_STAT) rd_data = DW'(stat_reg);
      if (word == WORD_IEN)  rd_data = DW'(ien_reg);
    end
  end

  assign bus.dataout = rd_data;
endmodule

// File: tb/tb_sc_io_port_bank.sv
// Directed bench for sc_io_port_bank with a register-map level model checked every cycle.
module tb_sc_io_port_bank;
  localparam int DW      = 32;
  localparam int NUM_OUT = 3;
  localparam int NUM_IN  = 2;
  localparam int DEB     = 4;
  localparam logic [31:0] BASE = 32'h80;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NUM_IN*DW-1:0]  in_port;
  logic [NUM_OUT*DW-1:0] out_port;
  logic                  irq;

  int vectors     = 0;
  int miscompares = 0;

  sc_io_port_bank_if #(.DW(DW)) bus_i ();

  sc_io_port_bank #(
    .DW(DW), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .DEB_CYCLES(DEB), .BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus_i),
    .out_port(out_port), .in_port(in_port), .irq(irq)
  );

  always #5 clock = ~clock;

  // Model state: what each register must hold according to the register map.
  logic [31:0] m_out    [NUM_OUT];
  logic [31:0] m_s1     [NUM_IN];
  logic [31:0] m_s2     [NUM_IN];
  logic [31:0] m_stable [NUM_IN];
  int          m_run    [NUM_IN];
  logic [31:0] m_stat = 0;
  logic [31:0] m_ien  = 0;
  logic        m_irq  = 0;
  localparam logic [31:0] IN_MASK = (32'd1 << NUM_IN) - 32'd1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_sel(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd127);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int off;
    if (!m_sel(a)) return 32'd0;
    off = int'((a - BASE) & ~32'd3);
    if (off < 4*NUM_OUT) return m_out[off/4];
    if (off >= 64 && off < 64 + 4*NUM_IN) return m_stable[(off-64)/4];
    if (off == 96) return m_stat;
    if (off == 100) return m_ien;
    return 32'd0;
  endfunction

  function automatic logic [NUM_OUT*DW-1:0] m_ports();
    logic [NUM_OUT*DW-1:0] v;
    for (int i = 0; i < NUM_OUT; i++) v[i*DW +: DW] = m_out[i];
    return v;
  endfunction

  // Model update on every active edge (or asynchronously on reset).
  initial begin
    logic [31:0] chg;
    logic [31:0] clr;
    logic        wrv;
    int          off;
    for (int i = 0; i < NUM_OUT; i++) m_out[i] = 0;
    for (int j = 0; j < NUM_IN; j++) begin
      m_s1[j] = 0; m_s2[j] = 0; m_stable[j] = 0; m_run[j] = 0;
    end
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int i = 0; i < NUM_OUT; i++) m_out[i] = 0;
        for (int j = 0; j < NUM_IN; j++) begin
          m_s1[j] = 0; m_s2[j] = 0; m_stable[j] = 0; m_run[j] = 0;
        end
        m_stat = 0; m_ien = 0; m_irq = 0;
      end else begin
        chg = 0;
        // A value is accepted once it has differed from the stable value for DEB consecutive edges.
        for (int j = 0; j < NUM_IN; j++) begin
          if (m_s2[j] != m_stable[j]) begin
            m_run[j]++;
            if (m_run[j] == DEB) begin
              m_stable[j] = m_s2[j];
              m_run[j]    = 0;
              chg[j]      = 1'b1;
            end
          end else begin
            m_run[j] = 0;
          end
        end
        for (int j = 0; j < NUM_IN; j++) begin
          m_s2[j] = m_s1[j];
          m_s1[j] = in_port[j*DW +: DW];
        end
        wrv = bus_i.we && m_sel(bus_i.addr);
        off = int'((bus_i.addr - BASE) & ~32'd3);
        clr = (wrv && off == 96) ? bus_i.datain : 32'd0;
        m_stat = ((m_stat & ~clr) | chg) & IN_MASK;
        if (wrv && off == 100) m_ien = bus_i.datain & IN_MASK;
        if (wrv && off < 4*NUM_OUT) m_out[off/4] = bus_i.datain;
        m_irq = |(m_stat & m_ien);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      chk("cyc_out_port", out_port, m_ports());
      chk("cyc_irq", irq, m_irq);
      chk("cyc_sel", bus_i.sel, m_sel(bus_i.addr));
      chk("cyc_dataout", bus_i.dataout, m_read(bus_i.addr));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_i.addr = a; bus_i.datain = d; bus_i.we = 1'b1;
    tick();
    bus_i.we = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus_i.addr = a; bus_i.we = 1'b0;
    #1;
    chk(name, bus_i.dataout, exp);
    $display("vec %s addr=%0h dataout=%0h", name, a, bus_i.dataout);
  endtask

  initial begin
    bus_i.addr = 0; bus_i.datain = 0; bus_i.we = 0; in_port = 0;
    #1 reset = 1'b1;
    #12 reset = 1'b0;
    tick();
    chk("rst_out_port", out_port, '0);
    chk("rst_irq", irq, 1'b0);
    rdchk("rst_out0", 32'h80, 32'h0);
    rdchk("rst_stat", 32'hE0, 32'h0);

    // Output register store and readback
    wr(32'h84, 32'h0000_00A5);
    chk("t2_port1", out_port[63:32], 32'hA5);
    chk("t2_port0", out_port[31:0], 32'h0);
    chk("t2_port2", out_port[95:64], 32'h0);
    rdchk("t2_rd1", 32'h84, 32'hA5);
    wr(32'hC0, 32'hFFFF_FFFF);
    rdchk("t2_in0_ro", 32'hC0, 32'h0);
    chk("t2_in_wr_noeffect", out_port, {32'h0, 32'hA5, 32'h0});
    wr(32'h80, 32'hDEAD_BEEF);
    wr(32'h88, 32'h1234_5678);
    rdchk("t2_rd0", 32'h80, 32'hDEAD_BEEF);
    rdchk("t2_rd2", 32'h88, 32'h1234_5678);
    // Read during a write sees the old value
    bus_i.addr = 32'h84; bus_i.datain = 32'h5A; bus_i.we = 1'b1;
    #1 chk("t2_rd_during_wr", bus_i.dataout, 32'hA5);
    tick();
    bus_i.we = 1'b0;
    rdchk("t2_rd_after_wr", 32'h84, 32'h5A);

    // Debounce latency: accepted exactly 2+DEB edges after the raw change
    in_port[31:0] = 32'h1F;
    repeat (5) tick();
    rdchk("t3_in0_edge5", 32'hC0, 32'h0);
    tick();
    rdchk("t3_in0_edge6", 32'hC0, 32'h1F);
    rdchk("t3_stat", 32'hE0, 32'h1);
    wr(32'hE0, 32'h1);
    rdchk("t3_stat_clr", 32'hE0, 32'h0);

    // Short pulses on in1 are rejected
    in_port[63:32] = 32'h3;
    repeat (2) tick();
    in_port[63:32] = 32'h0;
    repeat (8) tick();
    rdchk("t4_in1_p2", 32'hC4, 32'h0);
    rdchk("t4_stat_p2", 32'hE0, 32'h0);
    in_port[63:32] = 32'h3;
    repeat (3) tick();
    in_port[63:32] = 32'h0;
    repeat (8) tick();
    rdchk("t4_in1_p3", 32'hC4, 32'h0);
    rdchk("t4_stat_p3", 32'hE0, 32'h0);

    // Interrupt enable, set-wins over clear, W1C deassert, masking
    wr(32'hE4, 32'h1);
    rdchk("t5_ien", 32'hE4, 32'h1);
    in_port[31:0] = 32'h0;
    repeat (5) tick();
    chk("t5_irq_edge5", irq, 1'b0);
    tick();
    chk("t5_irq_edge6", irq, 1'b1);
    rdchk("t5_stat_set", 32'hE0, 32'h1);
    in_port[31:0] = 32'h5;
    repeat (5) tick();
    wr(32'hE0, 32'h1);
    rdchk("t5_stat_setwins", 32'hE0, 32'h1);
    chk("t5_irq_setwins", irq, 1'b1);
    rdchk("t5_in0_new", 32'hC0, 32'h5);
    wr(32'hE0, 32'h1);
    chk("t5_irq_cleared", irq, 1'b0);
    rdchk("t5_stat_cleared", 32'hE0, 32'h0);
    in_port[31:0] = 32'h0;
    repeat (6) tick();
    chk("t5_irq_again", irq, 1'b1);
    wr(32'hE4, 32'h0);
    chk("t5_irq_masked", irq, 1'b0);
    rdchk("t5_stat_masked", 32'hE0, 32'h1);
    wr(32'hE4, 32'h1);
    chk("t5_irq_unmasked", irq, 1'b1);

    // Window boundaries and unmapped offsets
    rdchk("t6_unmapped_7c", 32'hFC, 32'h0);
    chk("t6_sel_fc", bus_i.sel, 1'b1);
    wr(32'hFC, 32'hFFFF_FFFF);
    rdchk("t6_below", 32'h7C, 32'h0);
    chk("t6_sel_7c", bus_i.sel, 1'b0);
    wr(32'h7C, 32'hFFFF_FFFF);
    rdchk("t6_above", 32'h100, 32'h0);
    chk("t6_sel_100", bus_i.sel, 1'b0);
    wr(32'h100, 32'hFFFF_FFFF);
    rdchk("t6_top_byte", 32'hFF, 32'h0);
    chk("t6_sel_ff", bus_i.sel, 1'b1);
    rdchk("t6_stat_lsbs", 32'hE3, 32'h1);
    chk("t6_ports_kept", out_port, {32'h1234_5678, 32'h5A, 32'hDEAD_BEEF});
    chk("t6_irq_kept", irq, 1'b1);

    // Asynchronous reset in the middle of a debounce count
    in_port[63:32] = 32'h3;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("t7_rst_out_port", out_port, '0);
    chk("t7_rst_irq", irq, 1'b0);
    in_port = '0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    rdchk("t7_stat", 32'hE0, 32'h0);
    rdchk("t7_in1", 32'hC4, 32'h0);
    rdchk("t7_out0", 32'h80, 32'h0);
    rdchk("t7_ien", 32'hE4, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
